vga_fb_load_arbiter: RTL and testbench

VGA_FB_LOAD_ARBITER -- requirements
Module: vga_fb_load_arbiter

---
 rtl/vga_pkg.sv | 12 +
 rtl/vga_fb_window_addr.sv | 29 ++
 rtl/vga_fb_load_arbiter.sv | 146 ++++++++++++++
 tb/tb_vga_fb_load_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and loader FSM encoding for the frame-buffer arbiter.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_ACTIVE = 480;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_UNPACK = 1'b1
    } load_state_e;

endpackage

// File: rtl/vga_fb_window_addr.sv
// Centred-window detection and linear read-address generation for the VGA reader.
module vga_fb_window_addr
    import vga_pkg::*;
#(
    parameter int FRAME_WIDTH  = 256,
    parameter int FRAME_HEIGHT = 256,
    parameter int ADDR_W       = 16
) (
    input  logic [9:0]        x_position_vga,
    input  logic [8:0]        y_position_vga,
    output logic              in_window,
    output logic [ADDR_W-1:0] rd_addr
);

    localparam int LEFT = (VGA_H_ACTIVE - FRAME_WIDTH) / 2;
    localparam int TOP  = (VGA_V_ACTIVE - FRAME_HEIGHT) / 2;

    int x_i;
    int y_i;

    always_comb begin
        x_i = int'(x_position_vga);
        y_i = int'(y_position_vga);
        in_window = (x_i >= LEFT) && (x_i < LEFT + FRAME_WIDTH) &&
                    (y_i >= TOP)  && (y_i < TOP + FRAME_HEIGHT);
        rd_addr = ADDR_W'((x_i - LEFT) + (y_i - TOP) * FRAME_WIDTH);
    end

endmodule

// File: rtl/vga_fb_load_arbiter.sv
// Shares a single-port 1-bpp frame buffer between a UART byte loader and the VGA reader.
// Build option: define VGA_FB_BORDER_COLOR_EN to add a border_color input for out-of-window pixels.
//
//   state     | meaning
//   ST_IDLE   | waiting for a UART byte (rx_ready high unless frame_start)
//   ST_UNPACK | writing the captured byte LSB first, one bit per free cycle
module vga_fb_load_arbiter
    import vga_pkg::*;
#(
    parameter int FRAME_WIDTH  = 256,
    parameter int FRAME_HEIGHT = 256,
    parameter int ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              frame_start,
    input  logic [9:0]        x_position_vga,
    input  logic [8:0]        y_position_vga,
`ifdef VGA_FB_BORDER_COLOR_EN
    input  logic [7:0]        border_color,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_wdata,
    input  logic              mem_rdata,
    output logic [7:0]        vga_data_out,
    output logic              frame_done
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_WIDTH * FRAME_HEIGHT - 1);

    load_state_e       state;
    load_state_e       state_nxt;
    logic [ADDR_W-1:0] pix_ptr;
    logic [2:0]        bit_idx;
    logic [7:0]        byte_q;
    logic              rd_own;
    logic [ADDR_W-1:0] rd_addr;
    logic              accept;
    logic              wr_bit;
    logic              win_d1;
    logic              win_d2;
    logic              rd_q;
    logic [7:0]        border;

`ifdef VGA_FB_BORDER_COLOR_EN
    assign border = border_color;
`else
    assign border = 8'h00;
`endif

    vga_fb_window_addr #(
        .FRAME_WIDTH  (FRAME_WIDTH),
        .FRAME_HEIGHT (FRAME_HEIGHT),
        .ADDR_W       (ADDR_W)
    ) u_window (
        .x_position_vga (x_position_vga),
        .y_position_vga (y_position_vga),
        .in_window      (rd_own),
        .rd_addr        (rd_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The reader always wins the port; a pending bit simply waits for a free cycle.
    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b0;
        accept    = 1'b0;
        wr_bit    = 1'b0;
        mem_addr  = pix_ptr;
        mem_we    = 1'b0;
        mem_wdata = 1'b0;
        case (state)
            ST_IDLE: begin
                rx_ready = !rst && !frame_start;
                accept   = rx_ready && rx_valid;
                if (accept) begin
                    state_nxt = ST_UNPACK;
                end
            end
            ST_UNPACK: begin
                wr_bit = !rst && !frame_start && !rd_own;
                if (wr_bit && bit_idx == 3'd7) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (frame_start) begin
            state_nxt = ST_IDLE;
        end
        if (rd_own) begin
            mem_addr = rd_addr;
        end else if (wr_bit) begin
            mem_we    = 1'b1;
            mem_wdata = byte_q[bit_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_ptr    <= '0;
            bit_idx    <= 3'd0;
            byte_q     <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wr_bit && (pix_ptr == LAST_PIX);
            if (frame_start) begin
                pix_ptr <= '0;
                bit_idx <= 3'd0;
            end else if (accept) begin
                byte_q  <= rx_data;
                bit_idx <= 3'd0;
            end else if (wr_bit) begin
                bit_idx <= bit_idx + 3'd1;
                pix_ptr <= (pix_ptr == LAST_PIX) ? '0 : pix_ptr + 1'b1;
            end
        end
    end

    // Read data is retimed alongside the second flag stage so both stay aligned with the pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_d1 <= 1'b0;
            win_d2 <= 1'b0;
            rd_q   <= 1'b0;
        end else begin
            win_d1 <= rd_own;
            win_d2 <= win_d1;
            rd_q   <= mem_rdata;
        end
    end

    assign vga_data_out = win_d2 ? {8{rd_q}} : border;

endmodule

// File: tb/tb_vga_fb_load_arbiter.sv
// Self-checking bench for vga_fb_load_arbiter: per-cycle reference model plus directed scenarios.
module tb_vga_fb_load_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        frame_start;
    logic [9:0]  x_pos;
    logic [8:0]  y_pos;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic        mem_wdata;
    bit          mem_rdata;
    logic [7:0]  vga_data_out;
    logic        frame_done;

    always #5 clk = ~clk;

    vga_fb_load_arbiter #(
        .FRAME_WIDTH  (256),
        .FRAME_HEIGHT (256),
        .ADDR_W       (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .frame_start    (frame_start),
        .x_position_vga (x_pos),
        .y_position_vga (y_pos),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .vga_data_out   (vga_data_out),
        .frame_done     (frame_done)
    );

    bit fb_mem [65536];

    always @(posedge clk) begin
        if (mem_we) fb_mem[mem_addr] <= mem_wdata;
        mem_rdata <= fb_mem[mem_addr];
    end

    typedef struct {
        int addr;
        bit d;
    } wr_t;

    int   checks   = 0;
    int   failures = 0;
    bit   armed    = 1'b0;
    int   m_ptr    = 0;
    int   m_pend   = 0;
    logic [7:0] m_byte = 8'h00;
    bit   m_done   = 1'b0;
    logic [7:0] m_vnow  = 8'h00;
    logic [7:0] m_vnext = 8'h00;
    bit   m_fb [65536];
    wr_t  wlog [$];
    int   fd_count     = 0;
    int   fd_prev_addr = -1;
    int   last_wr_addr = -1;
    int   win_writes   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference model: window arithmetic, a pending-bit count and a shadow frame buffer.
    always @(negedge clk) begin
        bit         win;
        int         ra;
        bit         e_ready;
        bit         e_we;
        bit         e_wd;
        int         e_addr;
        logic [7:0] vc;
        wr_t        w;
        win = (int'(x_pos) >= 192) && (int'(x_pos) < 448) &&
              (int'(y_pos) >= 112) && (int'(y_pos) < 368);
        ra = (int'(x_pos) - 192) + (int'(y_pos) - 112) * 256;
        e_ready = !rst && (m_pend == 0) && !frame_start;
        e_we    = !rst && !frame_start && (m_pend > 0) && !win;
        e_addr  = win ? ra : m_ptr;
        e_wd    = 1'b0;
        if (m_pend > 0) e_wd = m_byte[8 - m_pend];
        vc = 8'h00;
        if (win) vc = {8{m_fb[ra]}};

        if (armed) begin
            chk("rx_ready", rx_ready, e_ready);
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr[15:0]);
            if (e_we) chk("mem_wdata", mem_wdata, e_wd);
            chk("frame_done", frame_done, m_done);
            chk("vga_data_out", vga_data_out, m_vnow);
        end

        if (frame_done === 1'b1) begin
            fd_count++;
            fd_prev_addr = last_wr_addr;
        end
        if (mem_we === 1'b1) begin
            w.addr = int'(mem_addr);
            w.d    = mem_wdata;
            wlog.push_back(w);
            last_wr_addr = int'(mem_addr);
            if (win) win_writes++;
        end

        if (rst) begin
            m_ptr   = 0;
            m_pend  = 0;
            m_done  = 1'b0;
            m_vnow  = 8'h00;
            m_vnext = 8'h00;
            armed   = 1'b1;
        end else begin
            m_vnow  = m_vnext;
            m_vnext = vc;
            m_done  = 1'b0;
            if (frame_start) begin
                m_ptr  = 0;
                m_pend = 0;
            end else if (e_we) begin
                m_fb[m_ptr] = e_wd;
                m_done = (m_ptr == 65535);
                m_ptr  = (m_ptr + 1) % 65536;
                m_pend--;
            end else if (e_ready && rx_valid) begin
                m_pend = 8;
                m_byte = rx_data;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (rx_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout byte=%0h not accepted within 40 cycles", b);
        end
    endtask

    initial begin
        #(64'd1500000);
        $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_a5 [8];
        bit exp_3c [8];
        exp_a5 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_3c = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; frame_start = 1'b0;
        x_pos = 10'd0; y_pos = 9'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_rx_ready", rx_ready, 1);
        chk("reset_mem_we", mem_we, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_vga", vga_data_out, 0);
        chk("reset_frame_done", frame_done, 0);
        @(posedge clk); #1;

        // 0xA5 with no reader activity
        wlog.delete();
        send_byte(8'hA5);
        tick(10);
        chk("a5_count", wlog.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a5_addr%0d", i), wlog[i].addr, i);
            chk($sformatf("a5_bit%0d", i), wlog[i].d, exp_a5[i]);
        end
        @(negedge clk);
        chk("a5_ready_after", rx_ready, 1);
        @(posedge clk); #1;

        // reader in window during unpack cycles 3..5
        wlog.delete();
        win_writes = 0;
        send_byte(8'h3C);
        tick(2);
        x_pos = 10'd200; y_pos = 9'd120;
        tick(3);
        x_pos = 10'd0; y_pos = 9'd0;
        tick(10);
        chk("stall_count", wlog.size(), 8);
        chk("stall_in_window_writes", win_writes, 0);
        for (int i = 0; i < 8; i++) chk($sformatf("stall_addr%0d", i), wlog[i].addr, 8 + i);

        // reader addressing and output latency
        x_pos = 10'd447; y_pos = 9'd367;
        @(negedge clk);
        chk("rd_addr_last", mem_addr, 16'hFFFF);
        @(posedge clk); #1;
        x_pos = 10'd448;
        @(negedge clk);
        chk("rd_addr_outside", mem_addr, 16);
        @(posedge clk); #1;
        x_pos = 10'd192; y_pos = 9'd112;
        @(negedge clk);
        chk("rd_addr_origin", mem_addr, 0);
        @(posedge clk); #1;
        x_pos = 10'd0; y_pos = 9'd0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("vga_in_window", vga_data_out, 8'hFF);
        @(posedge clk); #1;
        @(negedge clk);
        chk("vga_out_window", vga_data_out, 8'h00);
        @(posedge clk); #1;

        // frame_start while bit 4 is due
        wlog.delete();
        send_byte(8'hFF);
        tick(4);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        rx_data = 8'h55; rx_valid = 1'b1; frame_start = 1'b1;
        @(negedge clk);
        chk("fs_blocks_ready", rx_ready, 0);
        @(posedge clk); #1;
        frame_start = 1'b0; rx_valid = 1'b0;
        tick(2);
        chk("fs_count", wlog.size(), 4);
        chk("fs_last_addr", wlog[3].addr, 19);
        wlog.delete();
        send_byte(8'h81);
        tick(10);
        chk("fs_next_count", wlog.size(), 8);
        chk("fs_next_addr", wlog[0].addr, 0);

        // reset in the middle of an unpack
        wlog.delete();
        send_byte(8'h0F);
        tick(2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready_low", rx_ready, 0);
        chk("rst_we_low", mem_we, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_after_we", mem_we, 0);
        chk("rst_after_addr", mem_addr, 0);
        chk("rst_after_done", frame_done, 0);
        chk("rst_after_vga", vga_data_out, 0);
        chk("rst_after_ready", rx_ready, 1);
        chk("rst_partial_count", wlog.size(), 2);
        @(posedge clk); #1;
        wlog.delete();
        send_byte(8'h3C);
        tick(10);
        chk("rst_next_count", wlog.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rst_next_addr%0d", i), wlog[i].addr, i);
            chk($sformatf("rst_next_bit%0d", i), wlog[i].d, exp_3c[i]);
        end

        // one full frame: 8192 bytes from pixel 0
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        fd_count = 0;
        for (int i = 0; i < 8192; i++) send_byte(i[7:0]);
        tick(12);
        chk("frame_done_count", fd_count, 1);
        chk("frame_done_after_addr", fd_prev_addr, 65535);
        wlog.delete();
        send_byte(8'hC3);
        tick(10);
        chk("wrap_count", wlog.size(), 8);
        chk("wrap_first_addr", wlog[0].addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
